// File: rtl/rx_funcmod.sv
// UART 8N1 receive function module: on iCall, hunts for a start bit, samples
// eight data bits LSB-first at bit centres, checks the stop bit and reports done/error.
module rx_funcmod #(
    parameter int BPS_DIV = 434
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       RXD,
    input  logic       iCall,
    output logic       oDone,
    output logic       oErr,
    output logic [7:0] oData
);

    localparam int CW = $clog2(BPS_DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(BPS_DIV - 1);
    localparam logic [CW-1:0] SAMPLE_PT = CW'(BPS_DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE,
        S_WAITHI
    } state_t;

    state_t          state_q;
    logic            rxd_s1_q;
    logic            rxd_s2_q;
    logic            rxd_prev_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            done_q;
    logic            err_q;
    logic            fall;
    logic            sample;
    logic            counting;

    assign fall     = rxd_prev_q & ~rxd_s2_q;
    assign sample   = (cnt_q == SAMPLE_PT);
    assign counting = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

    // Bit-period counter runs only while framing; it sits at zero in HUNT so
    // the cycle after the detected edge starts the start-bit slot at count 0.
    always_comb begin
        cnt_d = '0;
        if (counting) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rxd_s1_q   <= RXD;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            cnt_q      <= cnt_d;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iCall) state_q <= S_HUNT;
                end
                S_HUNT: begin
                    if (!iCall)    state_q <= S_IDLE;
                    else if (fall) state_q <= S_START;
                end
                S_START: begin
                    if (!iCall) begin
                        state_q <= S_IDLE;
                    end else if (sample) begin
                        // A line already back high at mid start bit was a glitch.
                        state_q   <= rxd_s2_q ? S_HUNT : S_DATA;
                        bit_idx_q <= '0;
                    end
                end
                S_DATA: begin
                    if (!iCall) begin
                        state_q <= S_IDLE;
                    end else if (sample) begin
                        shift_q[bit_idx_q] <= rxd_s2_q;
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                S_STOP: begin
                    if (!iCall) begin
                        state_q <= S_IDLE;
                    end else if (sample) begin
                        if (rxd_s2_q) begin
                            data_q  <= shift_q;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_WAITHI;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_WAITHI: begin
                    if (rxd_s2_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oDone = done_q;
    assign oErr  = err_q;
    assign oData = data_q;

endmodule
